// File: rtl/apb_modport_pkg.sv
// Shared constants and master state encoding for the APB subsystem.
package apb_modport_pkg;

  localparam int APB_AW = 9;
  localparam int APB_DW = 8;
  localparam int APB_IW = APB_AW - 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

endpackage

// File: rtl/apb_mem_slave.sv
// Memory-backed APB3 slave; zero wait states, or exactly one when APB_WAIT_STATE_EN is defined.
module apb_mem_slave
  import apb_modport_pkg::*;
#(
  parameter int IW = APB_IW,
  parameter int DW = APB_DW
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [IW-1:0] paddr,
  input  logic [DW-1:0] pwdata,
  output logic [DW-1:0] prdata,
  output logic          pready
);

  logic [DW-1:0] mem [0:(1<<IW)-1];
  logic          access;

  assign access = psel & penable;

`ifdef APB_WAIT_STATE_EN
  // High only in the second ACCESS cycle; cleared by the completing edge.
  logic wait_done;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wait_done <= 1'b0;
    end else if (access && !wait_done) begin
      wait_done <= 1'b1;
    end else begin
      wait_done <= 1'b0;
    end
  end

  assign pready = access & wait_done;
`else
  assign pready = access;
`endif

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < (1 << IW); i++) begin
        mem[i] <= '0;
      end
    end else if (pready && pwrite) begin
      mem[paddr] <= pwdata;
    end
  end

  assign prdata = (access && !pwrite) ? mem[paddr] : '0;

endmodule

// File: rtl/apb_modport.sv
// APB3 master FSM with two memory slaves; address MSB selects the slave.
// Build option: APB_WAIT_STATE_EN adds one slave wait state per transfer.
module apb_modport
  import apb_modport_pkg::*;
#(
  parameter int AW = APB_AW,
  parameter int DW = APB_DW
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          transfer,
  input  logic          read_write,
  input  logic [AW-1:0] apb_write_paddr,
  input  logic [DW-1:0] apb_write_data,
  input  logic [AW-1:0] apb_read_paddr,
  output logic [DW-1:0] apb_read_data_out
);

  localparam int IW = AW - 1;

  state_t        state, next_state;
  logic [AW-1:0] paddr_q, paddr;
  logic [DW-1:0] pwdata_q, pwdata;
  logic          pwrite_q, pwrite;
  logic          psel1, psel2, penable;
  logic [DW-1:0] prdata1, prdata2, prdata;
  logic          pready1, pready2, pready;

  // SETUP drives the request inputs directly; ACCESS replays what SETUP captured.
  always_comb begin
    paddr  = paddr_q;
    pwdata = pwdata_q;
    pwrite = pwrite_q;
    if (state == SETUP) begin
      paddr  = read_write ? apb_write_paddr : apb_read_paddr;
      pwdata = apb_write_data;
      pwrite = read_write;
    end
  end

  assign psel1   = (state != IDLE) & ~paddr[AW-1];
  assign psel2   = (state != IDLE) &  paddr[AW-1];
  assign penable = (state == ACCESS);
  assign pready  = psel1 ? pready1 : pready2;
  assign prdata  = psel1 ? prdata1 : prdata2;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (transfer) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (pready) next_state = transfer ? SETUP : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
    end else if (state == SETUP) begin
      paddr_q  <= paddr;
      pwdata_q <= pwdata;
      pwrite_q <= pwrite;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      apb_read_data_out <= '0;
    end else if (state == ACCESS && pready && !pwrite_q) begin
      apb_read_data_out <= prdata;
    end
  end

  apb_mem_slave #(.IW(IW), .DW(DW)) u_slave1 (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (psel1),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr[IW-1:0]),
    .pwdata  (pwdata),
    .prdata  (prdata1),
    .pready  (pready1)
  );

  apb_mem_slave #(.IW(IW), .DW(DW)) u_slave2 (
    .pclk    (pclk),
    .presetn (presetn),
    .psel    (psel2),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr[IW-1:0]),
    .pwdata  (pwdata),
    .prdata  (prdata2),
    .pready  (pready2)
  );

endmodule

// File: tb/tb_apb_modport.sv
// Directed plus randomized bench for apb_modport against a flat 512-entry memory model.
module tb_apb_modport;
  import apb_modport_pkg::*;

`ifdef APB_WAIT_STATE_EN
  localparam int ACC = 2;
`else
  localparam int ACC = 1;
`endif

  logic       pclk = 1'b0;
  logic       presetn;
  logic       transfer;
  logic       read_write;
  logic [8:0] apb_write_paddr;
  logic [7:0] apb_write_data;
  logic [8:0] apb_read_paddr;
  logic [7:0] apb_read_data_out;

  int tests = 0;
  int fails = 0;

  // Full 9-bit address is a unique location: MSB picks slave, rest is the index.
  logic [7:0] mem [0:511];
  logic [7:0] exp_rd;

  apb_modport dut (
    .pclk              (pclk),
    .presetn           (presetn),
    .transfer          (transfer),
    .read_write        (read_write),
    .apb_write_paddr   (apb_write_paddr),
    .apb_write_data    (apb_write_data),
    .apb_read_paddr    (apb_read_paddr),
    .apb_read_data_out (apb_read_data_out)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    exp_rd = 8'h00;
  endtask

  // Called at a negedge; with hold=1 it returns just before the completing edge
  // so the next call issues back-to-back.
  task automatic xfer(input logic rw, input logic [8:0] addr, input logic [7:0] data,
                      input bit hold);
    read_write = rw;
    if (rw) begin
      apb_write_paddr = addr;
      apb_write_data  = data;
      apb_read_paddr  = 9'($urandom);
    end else begin
      apb_read_paddr  = addr;
      apb_write_paddr = 9'($urandom);
      apb_write_data  = 8'($urandom);
    end
    transfer = 1'b1;
    @(posedge pclk); @(negedge pclk);
    check("setup_state", 32'(dut.state), 32'(SETUP));
    check("setup_penable", 32'(dut.penable), 32'd0);
    check("setup_psel2", 32'(dut.psel2), 32'(addr[8]));
    transfer = hold;
    @(posedge pclk); @(negedge pclk);
    check("access_state", 32'(dut.state), 32'(ACCESS));
    // Inputs wander during ACCESS; the transfer must not notice.
    apb_write_paddr = 9'($urandom);
    apb_read_paddr  = 9'($urandom);
    apb_write_data  = 8'($urandom);
    read_write      = 1'($urandom);
    check("rd_not_early", 32'(apb_read_data_out), 32'(exp_rd));
    if (ACC == 2) begin
      @(posedge pclk); @(negedge pclk);
      check("wait_access", 32'(dut.state), 32'(ACCESS));
      check("rd_not_early_w", 32'(apb_read_data_out), 32'(exp_rd));
    end
    if (rw) mem[addr] = data;
    if (!hold) begin
      @(posedge pclk); @(negedge pclk);
      if (!rw) begin
        exp_rd = mem[addr];
        check("rd_data", 32'(apb_read_data_out), 32'(exp_rd));
      end else begin
        check("wr_keeps_rd", 32'(apb_read_data_out), 32'(exp_rd));
      end
      check("back_idle", 32'(dut.state), 32'(IDLE));
    end
  endtask

  initial begin
    logic       rw;
    logic [8:0] addr;
    bit         hold;

    clear_model();
    presetn = 1'b0;
    transfer = 1'b0;
    read_write = 1'b0;
    apb_write_paddr = '0;
    apb_read_paddr = '0;
    apb_write_data = '0;

    // Reset with random inputs
    repeat (4) begin
      @(negedge pclk);
      transfer        = 1'($urandom);
      read_write      = 1'($urandom);
      apb_write_paddr = 9'($urandom);
      apb_read_paddr  = 9'($urandom);
      apb_write_data  = 8'($urandom);
    end
    @(negedge pclk);
    check("rst_rdata", 32'(apb_read_data_out), 32'd0);
    check("rst_state", 32'(dut.state), 32'(IDLE));
    check("rst_psel1", 32'(dut.psel1), 32'd0);
    check("rst_psel2", 32'(dut.psel2), 32'd0);
    check("rst_penable", 32'(dut.penable), 32'd0);
    transfer = 1'b0;
    presetn  = 1'b1;
    @(negedge pclk);

    xfer(1'b0, 9'h005, 8'h00, 1'b0);

    // Single write/read on slave1; latency checked inside xfer
    xfer(1'b1, 9'h0A5, 8'h3C, 1'b0);
    xfer(1'b0, 9'h0A5, 8'h00, 1'b0);
    check("rd_0a5", 32'(apb_read_data_out), 32'h3C);

    // Slave select and independent data at equal indices
    xfer(1'b1, 9'h010, 8'h11, 1'b0);
    xfer(1'b1, 9'h110, 8'h22, 1'b0);
    xfer(1'b0, 9'h010, 8'h00, 1'b0);
    check("rd_010", 32'(apb_read_data_out), 32'h11);
    xfer(1'b0, 9'h110, 8'h00, 1'b0);
    check("rd_110", 32'(apb_read_data_out), 32'h22);

    // Slave boundary
    xfer(1'b1, 9'h0FF, 8'hAA, 1'b0);
    xfer(1'b1, 9'h100, 8'hBB, 1'b0);
    xfer(1'b0, 9'h0FF, 8'h00, 1'b0);
    check("rd_0ff", 32'(apb_read_data_out), 32'hAA);
    xfer(1'b0, 9'h100, 8'h00, 1'b0);
    check("rd_100", 32'(apb_read_data_out), 32'hBB);

    // Back-to-back writes: second xfer checks SETUP straight after ACCESS
    xfer(1'b1, 9'h1FF, 8'hFF, 1'b1);
    xfer(1'b1, 9'h000, 8'h01, 1'b0);
    xfer(1'b0, 9'h1FF, 8'h00, 1'b0);
    check("rd_1ff", 32'(apb_read_data_out), 32'hFF);
    xfer(1'b0, 9'h000, 8'h00, 1'b0);
    check("rd_000", 32'(apb_read_data_out), 32'h01);

    // Write data scrambled during ACCESS must not reach memory
    xfer(1'b1, 9'h020, 8'h55, 1'b0);
    xfer(1'b0, 9'h020, 8'h00, 1'b0);
    check("rd_020", 32'(apb_read_data_out), 32'h55);

    // Unknown inputs while idle
    transfer        = 1'b0;
    read_write      = 1'bx;
    apb_write_paddr = 'x;
    apb_read_paddr  = 'x;
    apb_write_data  = 'x;
    repeat (3) @(negedge pclk);
    check("x_state", 32'(dut.state), 32'(IDLE));
    check("x_penable", 32'(dut.penable), 32'd0);
    check("x_rdata", 32'(apb_read_data_out), 32'(exp_rd));

    // Randomized traffic over paired indices of both slaves
    for (int i = 0; i < 60; i++) begin
      rw   = 1'($urandom);
      addr = {1'($urandom), 4'b0, 4'($urandom)};
      hold = rw && (i < 59) && ($urandom_range(0, 1) == 1);
      xfer(rw, addr, 8'($urandom), hold);
    end

    // Reset during ACCESS of a write aborts it and clears memory
    read_write      = 1'b1;
    apb_write_paddr = 9'h030;
    apb_write_data  = 8'h77;
    transfer        = 1'b1;
    @(posedge pclk); @(negedge pclk);
    transfer = 1'b0;
    @(posedge pclk); #1;
    check("pre_abort_state", 32'(dut.state), 32'(ACCESS));
    presetn = 1'b0;
    #1;
    check("abort_state", 32'(dut.state), 32'(IDLE));
    check("abort_rdata", 32'(apb_read_data_out), 32'd0);
    check("abort_penable", 32'(dut.penable), 32'd0);
    clear_model();
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    xfer(1'b0, 9'h030, 8'h00, 1'b0);
    check("rd_030_abort", 32'(apb_read_data_out), 32'h00);
    xfer(1'b0, 9'h110, 8'h00, 1'b0);
    check("rd_110_cleared", 32'(apb_read_data_out), 32'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
